digit_entry_counter: RTL

- Parametrised N-digit, radix-R number-entry register driven by raw push-buttons, one button per digit.
- Each button is synchronised and debounced in the `clk` domain, then edge-detected into a single-cycle pulse.
- Each pulse increments or decrements its digit, with optional ripple carry/borrow across digits.
- Feeds the 7-segment scan/display path as the operand/score source; replaces per-button-clocked nibble counters with a fully synchronous design.

---
 rtl/digit_entry_counter_if.sv | 31 +++
 rtl/digit_entry_counter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/digit_entry_counter_if.sv
// digit_entry_counter_if
//   Groups the push-button inputs, mode controls and value outputs of the
//   digit entry counter.
//   btn       : raw asynchronous buttons, one per digit
//   dir       : 0 = increment, 1 = decrement
//   carry_en  : 1 = ripple carry/borrow between digits
//   clr       : synchronous load of the initial value, clears ovf
//   num       : current value, one 4-bit digit per nibble
//   btn_pulse : one-cycle accepted-press pulse per button
//   ovf       : sticky wrap/overflow flag
interface digit_entry_counter_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   btn;
    logic                dir;
    logic                carry_en;
    logic                clr;
    logic [4*DIGITS-1:0] num;
    logic [DIGITS-1:0]   btn_pulse;
    logic                ovf;

    modport master (
        output btn, dir, carry_en, clr,
        input  num, btn_pulse, ovf
    );

    modport slave (
        input  btn, dir, carry_en, clr,
        output num, btn_pulse, ovf
    );
endinterface

// File: rtl/digit_entry_counter.sv
// digit_entry_counter
//   N-digit, radix-R number-entry register driven by raw push-buttons.
//   Each button is synchronised, debounced and edge-detected into a single
//   pulse that steps its digit up or down, optionally rippling carry/borrow.
//   Ports:
//     clk : system clock, all state changes on its rising edge
//     rst : asynchronous active-high reset
//     bus : digit_entry_counter_if.slave (btn, dir, carry_en, clr in;
//           num, btn_pulse, ovf out)
module digit_entry_counter #(
    parameter int                  DIGITS          = 4,
    parameter int                  RADIX           = 16,
    parameter int                  DEBOUNCE_CYCLES = 4,
    parameter logic [4*DIGITS-1:0] INIT_VALUE      = 16'hABCD
) (
    input  logic                  clk,
    input  logic                  rst,
    digit_entry_counter_if.slave  bus
);
    localparam int                NUM_W    = 4 * DIGITS;
    localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]        RAD      = 5'(RADIX);

    logic [DIGITS-1:0] s1;
    logic [DIGITS-1:0] s2;
    logic [DIGITS-1:0] db;
    logic [DIGITS-1:0] db_prev;
    logic [DIGITS-1:0] pulse;
    logic [CNT_W-1:0]  cnt [DIGITS];

    logic [NUM_W-1:0]  num_r;
    logic [NUM_W-1:0]  num_next;
    logic              ovf_r;
    logic              ovf_next;
    logic              chain;
    logic [1:0]        amt;
    logic [4:0]        res;

    // Steps one digit by amt (0..2) in the given direction. Returns
    // {carry_or_borrow, new_digit}. An out-of-range digit behaves as RADIX-1,
    // so increment gives 0 with carry and decrement gives RADIX-2.
    function automatic logic [4:0] digit_step(input logic [3:0] d,
                                              input logic [1:0] a,
                                              input logic       down);
        logic [4:0] v;
        logic [4:0] s;
        v = (5'(d) >= RAD) ? (RAD - 5'd1) : 5'(d);
        if (a == 2'd0) begin
            digit_step = {1'b0, d};
        end else if (!down) begin
            s = v + 5'(a);
            if (s >= RAD) digit_step = {1'b1, 4'(s - RAD)};
            else          digit_step = {1'b0, s[3:0]};
        end else begin
            if (v < 5'(a)) digit_step = {1'b1, 4'(v + RAD - 5'(a))};
            else           digit_step = {1'b0, 4'(v - 5'(a))};
        end
    endfunction

    // Stage: two-flop synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.btn;
            s2 <= s1;
        end
    end

    // Stage: debounce; a change must persist DEBOUNCE_CYCLES cycles, any
    // return to the accepted level restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db <= '0;
            for (int i = 0; i < DIGITS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Stage: rising-edge detect into a one-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_prev <= '0;
            pulse   <= '0;
        end else begin
            db_prev <= db;
            pulse   <= db & ~db_prev;
        end
    end

    // Digit chain: with carry enabled each digit sees its own pulse plus the
    // carry/borrow from below; otherwise digits step independently and any
    // wrap of a pulsed digit flags overflow.
    always_comb begin
        num_next = num_r;
        ovf_next = ovf_r;
        chain    = 1'b0;
        amt      = 2'd0;
        res      = 5'd0;
        for (int i = 0; i < DIGITS; i++) begin
            amt = {1'b0, pulse[i]} + (bus.carry_en ? {1'b0, chain} : 2'd0);
            res = digit_step(num_r[4*i +: 4], amt, bus.dir);
            num_next[4*i +: 4] = res[3:0];
            if (bus.carry_en) chain = res[4];
            else if (res[4])  ovf_next = 1'b1;
        end
        if (bus.carry_en && chain) ovf_next = 1'b1;
    end

    // Stage: value register; clr wins over a coincident pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_r <= INIT_VALUE;
            ovf_r <= 1'b0;
        end else if (bus.clr) begin
            num_r <= INIT_VALUE;
            ovf_r <= 1'b0;
        end else if (|pulse) begin
            num_r <= num_next;
            ovf_r <= ovf_next;
        end
    end

    assign bus.num       = num_r;
    assign bus.ovf       = ovf_r;
    assign bus.btn_pulse = pulse;

endmodule
